// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit in front of a word-addressed data memory.
// Sub-word stores run as read-modify-write; loads return lane-extracted, extended data.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WriteData,
  input  logic [DATA_WIDTH-1:0] ReadData
);
  typedef enum logic [2:0] {IDLE, ACC, RMW_RD, RMW_WR, RESP} state_t;
  state_t                state_q, state_d;
  logic                  write_q, write_d, signed_q, signed_d, err_q, err_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, merge_q, merge_d, rdata_q, rdata_d;
  logic                  bad;
  logic [4:0]            sh;
  logic [DATA_WIDTH-1:0] lane, half, load_val, mask, merged;
  assign bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign sh = {addr_q[1:0], 3'b000};
  assign lane = ReadData >> sh;
  assign half = ReadData >> {addr_q[1], 4'b0000};
  assign load_val = size_q == 2'b00 ? {{(DATA_WIDTH-8){signed_q & lane[7]}}, lane[7:0]} :
                    size_q == 2'b01 ? {{(DATA_WIDTH-16){signed_q & half[15]}}, half[15:0]} :
                    ReadData;
  // Half stores are 2-aligned, so the byte-lane shift also places the half correctly.
  assign mask = (size_q == 2'b00 ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << sh;
  assign merged = (merge_q & ~mask) | ((wdata_q << sh) & mask);
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d = size_q;
    signed_d = signed_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d = req_write;
        size_d = req_size;
        signed_d = req_signed;
        addr_d = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d = bad;
        state_d = bad ? RESP : (req_write && req_size != 2'b10) ? RMW_RD : ACC;
      end
      ACC: begin
        rdata_d = write_q ? '0 : load_val;
        state_d = RESP;
      end
      RMW_RD: begin
        merge_d = ReadData;
        state_d = RMW_WR;
      end
      RMW_WR: state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q <= '0;
      signed_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q <= size_d;
      signed_q <= signed_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = state_q == RESP ? rdata_q : '0;
  assign resp_err = state_q == RESP && err_q;
  assign MemRead = (state_q == ACC && !write_q) || state_q == RMW_RD;
  assign MemWrite = (state_q == ACC && write_q) || state_q == RMW_WR;
  assign Address = (state_q == ACC || state_q == RMW_RD || state_q == RMW_WR) ?
                   {2'b00, addr_q[ADDR_WIDTH-1:2]} : '0;
  assign WriteData = (state_q == ACC && write_q) ? wdata_q : state_q == RMW_WR ? merged : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store traffic against a word-array reference model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, MemRead, MemWrite;
  logic [31:0] resp_rdata, WriteData, ReadData;
  logic [7:0]  Address;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        tb_we = 1'b0;
  logic [5:0]  tb_waddr = '0;
  logic [31:0] tb_wval = '0;
  logic [7:0]  last_waddr;
  logic [31:0] last_wdata;
  int          n_tests = 0, n_fail = 0;
  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .MemRead(MemRead),
    .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
  );
  always #5 clk = ~clk;
  assign ReadData = mem[Address[5:0]];
  always @(posedge clk)
    if (MemWrite) mem[Address[5:0]] <= WriteData;
    else if (tb_we) mem[tb_waddr] <= tb_wval;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic poke(input int i, input logic [31:0] v);
    @(negedge clk);
    tb_we = 1'b1;
    tb_waddr = 6'(i);
    tb_wval = v;
    ref_mem[i] = v;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [7:0] a,
                        input logic [31:0] wd, output logic [31:0] rd_obs);
    logic        bad, done, err_obs;
    int          idx, sh, hs, lat, exp_lat, nr, nw, exp_r, exp_w;
    logic [31:0] word, v, exp_rd;
    bad = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    idx = int'(a) / 4;
    sh = 8 * int'(a[1:0]);
    hs = a[1] ? 16 : 0;
    word = ref_mem[idx];
    exp_rd = 0;
    if (bad) begin
      exp_lat = 1; exp_r = 0; exp_w = 0;
    end else if (!w) begin
      exp_lat = 2; exp_r = 1; exp_w = 0;
      if (sz == 2'd0) begin
        v = (word >> sh) & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
        v = (word >> hs) & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF0000;
      end else v = word;
      exp_rd = v;
    end else if (sz == 2'd2) begin
      exp_lat = 2; exp_r = 0; exp_w = 1;
      ref_mem[idx] = wd;
    end else begin
      exp_lat = 3; exp_r = 1; exp_w = 1;
      if (sz == 2'd0) ref_mem[idx][sh +: 8] = wd[7:0];
      else ref_mem[idx][hs +: 16] = wd[15:0];
    end
    @(negedge clk);
    check("ready_before_req", 32'(req_ready), 1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1; nr = 0; nw = 0; done = 1'b0; rd_obs = 0; err_obs = 1'b0;
    while (!done) begin
      nr += int'(MemRead);
      nw += int'(MemWrite);
      if (MemWrite) begin last_waddr = Address; last_wdata = WriteData; end
      if (resp_valid) begin
        done = 1'b1; rd_obs = resp_rdata; err_obs = resp_err;
      end else if (lat >= 6) done = 1'b1;
      else begin
        @(posedge clk);
        #1 lat++;
      end
    end
    check("latency", lat, exp_lat);
    check("resp_err", 32'(err_obs), 32'(bad));
    check("resp_rdata", rd_obs, exp_rd);
    check("read_cycles", nr, exp_r);
    check("write_cycles", nw, exp_w);
    @(posedge clk);
    #1;
    check("resp_pulse_end", 32'(resp_valid), 0);
    check("ready_after", 32'(req_ready), 1);
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask
  initial begin
    logic [31:0] rd, exp3 [3];
    logic [1:0]  sz;
    logic [7:0]  a, la [3];
    int          r, k, errs;
    #12;
    check("rst_ready", 32'(req_ready), 1);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", 32'(resp_err), 0);
    check("rst_memrd", 32'(MemRead), 0);
    check("rst_memwr", 32'(MemWrite), 0);
    check("rst_addr", 32'(Address), 0);
    check("rst_wdata", WriteData, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    do_req(1'b1, 2'd2, 1'b0, 8'h08, 32'hDEADBEEF, rd);
    check("t1_waddr", 32'(last_waddr), 32'h02);
    check("t1_wdata", last_wdata, 32'hDEADBEEF);
    poke(2, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 8'h09, 32'h000000AA, rd);
    check("t2_wdata", last_wdata, 32'h1122AA44);
    check("t2_mem", mem[2], 32'h1122AA44);
    poke(2, 32'h80FF0000);
    do_req(1'b0, 2'd0, 1'b1, 8'h0B, 32'h0, rd);
    check("t3_sbyte", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b0, 8'h0B, 32'h0, rd);
    check("t3_ubyte", rd, 32'h00000080);
    do_req(1'b0, 2'd1, 1'b0, 8'h0A, 32'h0, rd);
    check("t3_uhalf", rd, 32'h000080FF);
    do_req(1'b0, 2'd1, 1'b1, 8'h0A, 32'h0, rd);
    check("t3_shalf", rd, 32'hFFFF80FF);
    do_req(1'b0, 2'd2, 1'b0, 8'h06, 32'h0, rd);
    check("t4_misaligned_rdata", rd, 0);
    do_req(1'b1, 2'd3, 1'b0, 8'h04, 32'h12345678, rd);
    check("t4_illegal_rdata", rd, 0);
    poke(5, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 8'h15; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("t5_rmw_wr_active", 32'(MemWrite), 1);
    rst_n = 1'b0;
    #1;
    check("t5_memwr_drop", 32'(MemWrite), 0);
    check("t5_memrd_drop", 32'(MemRead), 0);
    check("t5_no_resp", 32'(resp_valid), 0);
    repeat (2) begin
      @(posedge clk);
      #1 check("t5_no_resp_rst", 32'(resp_valid), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("t5_ready", 32'(req_ready), 1);
    check("t5_mem_kept", mem[5], 32'h11223344);
    @(posedge clk);
    #1 check("t5_no_resp_after", 32'(resp_valid), 0);
    la[0] = 8'h10; la[1] = 8'h24; la[2] = 8'h38;
    for (int i = 0; i < 3; i++) exp3[i] = ref_mem[la[i] / 4];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = la[0];
    @(posedge clk);
    #1;
    for (int e = 0; e < 10; e++) begin
      check("t6_ready", 32'(req_ready), 32'(e % 3 == 2 || e == 9));
      check("t6_resp_valid", 32'(resp_valid), 32'(e % 3 == 1 && e < 9));
      if (resp_valid) check("t6_rdata", resp_rdata, exp3[e / 3]);
      if (e == 0) req_addr = la[1];
      if (e == 3) req_addr = la[2];
      if (e == 6) req_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      sz = r < 3 ? 2'd0 : r < 6 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
      a = 8'($urandom);
      if ($urandom_range(0, 3) != 0) a = sz == 2'd2 ? {a[7:2], 2'b00} : sz == 2'd1 ? {a[7:1], 1'b0} : a;
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, rd);
    end
    errs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) errs++;
    check("final_mem_words", errs, 0);
    k = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
